// File: rtl/pong_playfield_if.sv
// rtl/pong_playfield_if.sv - pixel-in / colour-and-score-out bundle between sync generator and pong playfield
interface pong_playfield_if;
  logic       iActive;
  logic [9:0] iX;
  logic [9:0] iY;
  logic       iVGA_VS;
  logic       iP1Up;
  logic       iP1Dn;
  logic       iP2Up;
  logic       iP2Dn;
  logic [2:0] oRGB;
  logic [3:0] oScore1;
  logic [3:0] oScore2;
  logic       oGameOver;

  modport master (
    output iActive, iX, iY, iVGA_VS, iP1Up, iP1Dn, iP2Up, iP2Dn,
    input  oRGB, oScore1, oScore2, oGameOver
  );

  modport slave (
    input  iActive, iX, iY, iVGA_VS, iP1Up, iP1Dn, iP2Up, iP2Dn,
    output oRGB, oScore1, oScore2, oGameOver
  );
endinterface

// File: rtl/pong_playfield.sv
// rtl/pong_playfield.sv - pong game state updated once per frame plus registered per-pixel colour
// Optional green dashed centre net enabled by defining PONG_CENTRE_NET_EN.
module pong_playfield #(
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_S       = 8,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic            iclk,
  input  logic            irst,
  pong_playfield_if.slave bus
);

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_OVER  = 2'd2;

  localparam logic [9:0] BS      = 10'(BALL_S);
  localparam logic [9:0] BSPD    = 10'(BALL_SPEED);
  localparam logic [9:0] PW      = 10'(PADDLE_W);
  localparam logic [9:0] PH      = 10'(PADDLE_H);
  localparam logic [9:0] PSPD    = 10'(PADDLE_SPEED);
  localparam logic [9:0] X1      = 10'(P1_X);
  localparam logic [9:0] X2      = 10'(P2_X);
  localparam logic [9:0] PMAX    = 10'(480 - PADDLE_H);
  localparam logic [9:0] YMAX    = 10'(480 - BALL_S);
  localparam logic [9:0] Y_LIM   = 10'(480 - BALL_SPEED);
  localparam logic [9:0] X_LIM   = 10'(640 - BALL_SPEED);
  localparam logic [9:0] CX      = 10'(320 - BALL_S / 2);
  localparam logic [9:0] CY      = 10'(240 - BALL_S / 2);
  localparam logic [9:0] P_START = 10'(240 - PADDLE_H / 2);
  localparam logic [3:0] WIN4    = 4'(WIN_SCORE);

  localparam int SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

  logic           vs_d;
  logic           tick;
  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [SCW-1:0] serve_cnt;
  logic [9:0]     bx;
  logic [9:0]     by;
  logic           dx_neg;
  logic           dy_neg;
  logic [9:0]     p1y;
  logic [9:0]     p2y;
  logic [3:0]     score1;
  logic [3:0]     score2;
  logic           game_over;
  logic [2:0]     rgb;

  logic [9:0]     play_x;
  logic [9:0]     play_y;
  logic           play_dxn;
  logic           play_dyn;
  logic           hit_l;
  logic           hit_r;
  logic           miss_l;
  logic           miss_r;
  logic           win_l;
  logic           win_r;

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
    paddle_step = y;
    if (up && !dn)
      paddle_step = (y >= PSPD) ? y - PSPD : 10'd0;
    else if (dn && !up)
      paddle_step = (y + PSPD > PMAX) ? PMAX : y + PSPD;
  endfunction

  // Falling edge of active-low vsync lands in vertical blanking, so state never tears mid-frame.
  assign tick = vs_d & ~bus.iVGA_VS;

  assign hit_l = dx_neg && (bx <= X1 + PW) && (bx + BS > X1) &&
                 (by + BS > p1y) && (by < p1y + PH);
  assign hit_r = !dx_neg && (bx + BS >= X2) && (bx < X2 + PW) &&
                 (by + BS > p2y) && (by < p2y + PH);
  assign miss_l = dx_neg && (bx < BSPD) && !hit_l;
  assign miss_r = (bx + BS > X_LIM) && !hit_r;
  assign win_l  = miss_l && (score2 + 4'd1 == WIN4);
  assign win_r  = miss_r && (score1 + 4'd1 == WIN4);

  // Wall and paddle checks are independent, so a corner bounce flips both axes.
  always_comb begin
    play_x   = dx_neg ? bx - BSPD : bx + BSPD;
    play_y   = dy_neg ? by - BSPD : by + BSPD;
    play_dxn = dx_neg;
    play_dyn = dy_neg;
    if (dy_neg && by < BSPD) begin
      play_dyn = 1'b0;
      play_y   = 10'd0;
    end else if (!dy_neg && by + BS > Y_LIM) begin
      play_dyn = 1'b1;
      play_y   = YMAX;
    end
    if (hit_l) begin
      play_dxn = 1'b0;
      play_x   = X1 + PW;
    end else if (hit_r) begin
      play_dxn = 1'b1;
      play_x   = X2 - BS;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst)
      state <= S_SERVE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SERVE: if (tick && serve_cnt == SERVE_LAST) state_nxt = S_PLAY;
      S_PLAY:  if (tick && (miss_l || miss_r)) state_nxt = (win_l || win_r) ? S_OVER : S_SERVE;
      S_OVER:  state_nxt = S_OVER;
      default: state_nxt = S_SERVE;
    endcase
  end

  always_comb begin
    game_over = (state == S_OVER);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      vs_d      <= 1'b1;
      serve_cnt <= '0;
      bx        <= CX;
      by        <= CY;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      p1y       <= P_START;
      p2y       <= P_START;
      score1    <= 4'd0;
      score2    <= 4'd0;
    end else begin
      vs_d <= bus.iVGA_VS;
      if (tick) begin
        if (state != S_OVER) begin
          p1y <= paddle_step(p1y, bus.iP1Up, bus.iP1Dn);
          p2y <= paddle_step(p2y, bus.iP2Up, bus.iP2Dn);
        end
        if (state == S_SERVE)
          serve_cnt <= (serve_cnt == SERVE_LAST) ? '0 : serve_cnt + SCW'(1);
        if (state == S_PLAY) begin
          if (miss_l) begin
            score2 <= score2 + 4'd1;
            bx     <= CX;
            by     <= CY;
            dx_neg <= 1'b1;
          end else if (miss_r) begin
            score1 <= score1 + 4'd1;
            bx     <= CX;
            by     <= CY;
            dx_neg <= 1'b0;
          end else begin
            bx     <= play_x;
            by     <= play_y;
            dx_neg <= play_dxn;
            dy_neg <= play_dyn;
          end
        end
      end
    end
  end

  logic on_ball;
  logic on_p1;
  logic on_p2;
  assign on_ball = (bus.iX >= bx) && (bus.iX < bx + BS) && (bus.iY >= by) && (bus.iY < by + BS);
  assign on_p1   = (bus.iX >= X1) && (bus.iX < X1 + PW) && (bus.iY >= p1y) && (bus.iY < p1y + PH);
  assign on_p2   = (bus.iX >= X2) && (bus.iX < X2 + PW) && (bus.iY >= p2y) && (bus.iY < p2y + PH);

`ifdef PONG_CENTRE_NET_EN
  logic on_net;
  assign on_net = (bus.iX >= 10'd318) && (bus.iX <= 10'd321) && !bus.iY[4];
`endif

  always_ff @(posedge iclk) begin
    if (irst)
      rgb <= 3'b000;
    else if (!bus.iActive)
      rgb <= 3'b000;
    else if (on_ball || on_p1 || on_p2)
      rgb <= 3'b111;
`ifdef PONG_CENTRE_NET_EN
    else if (on_net)
      rgb <= 3'b010;
`endif
    else
      rgb <= 3'b000;
  end

  assign bus.oRGB      = rgb;
  assign bus.oScore1   = score1;
  assign bus.oScore2   = score2;
  assign bus.oGameOver = game_over;

endmodule

// File: tb/tb_pong_playfield.sv
// tb/tb_pong_playfield.sv - directed self-checking bench for pong_playfield
module tb_pong_playfield;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  logic [1:0] f_st;
  logic [9:0] f_bx;
  logic [9:0] f_by;
  logic       f_dxn;
  logic       f_dyn;
  logic [9:0] f_py;

`ifdef PONG_CENTRE_NET_EN
  localparam logic [2:0] NET_RGB = 3'b010;
`else
  localparam logic [2:0] NET_RGB = 3'b000;
`endif

  pong_playfield_if bus ();

  pong_playfield dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One vsync falling edge: the tick lands on the posedge after the first negedge.
  task automatic frame();
    @(negedge clk);
    bus.iVGA_VS = 1'b0;
    @(negedge clk);
    bus.iVGA_VS = 1'b1;
    @(negedge clk);
  endtask

  task automatic pix(input string tag, input logic act, input int x, input int y, input logic [2:0] exp);
    bus.iActive = act;
    bus.iX      = 10'(x);
    bus.iY      = 10'(y);
    @(negedge clk);
    check(tag, 32'(bus.oRGB), 32'(exp));
  endtask

  task force_ball(input logic [1:0] st, input int x, input int y, input logic dxn, input logic dyn);
    f_st  = st;
    f_bx  = 10'(x);
    f_by  = 10'(y);
    f_dxn = dxn;
    f_dyn = dyn;
    force dut.state  = f_st;
    force dut.bx     = f_bx;
    force dut.by     = f_by;
    force dut.dx_neg = f_dxn;
    force dut.dy_neg = f_dyn;
    #1;
    release dut.state;
    release dut.bx;
    release dut.by;
    release dut.dx_neg;
    release dut.dy_neg;
  endtask

  task force_p1(input int y);
    f_py = 10'(y);
    force dut.p1y = f_py;
    #1;
    release dut.p1y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    bus.iActive = 1'b0;
    bus.iX = 10'd0;
    bus.iY = 10'd0;
    bus.iVGA_VS = 1'b1;
    bus.iP1Up = 1'b0;
    bus.iP1Dn = 1'b0;
    bus.iP2Up = 1'b0;
    bus.iP2Dn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_rgb", 32'(bus.oRGB), 0);
    check("rst_score1", 32'(bus.oScore1), 0);
    check("rst_score2", 32'(bus.oScore2), 0);
    check("rst_gameover", 32'(bus.oGameOver), 0);
    check("rst_bx", 32'(dut.bx), 316);
    check("rst_by", 32'(dut.by), 236);
    check("rst_dxn", 32'(dut.dx_neg), 0);
    check("rst_dyn", 32'(dut.dy_neg), 0);
    check("rst_p1y", 32'(dut.p1y), 208);
    check("rst_p2y", 32'(dut.p2y), 208);
    check("rst_state", 32'(dut.state), 0);

    // Pixel path during SERVE: ball at (316,236), paddles at y 208..271.
    pix("px_ball_tl", 1'b1, 316, 236, 3'b111);
    pix("px_ball_br", 1'b1, 323, 243, 3'b111);
    pix("px_ball_rx", 1'b1, 324, 236, 3'b000);
    pix("px_inactive", 1'b0, 316, 236, 3'b000);
    pix("px_p1_tl", 1'b1, 16, 208, 3'b111);
    pix("px_p1_rx", 1'b1, 24, 208, 3'b000);
    pix("px_p1_br", 1'b1, 23, 271, 3'b111);
    pix("px_p1_by", 1'b1, 23, 272, 3'b000);
    pix("px_p2", 1'b1, 616, 240, 3'b111);
    pix("px_bg", 1'b1, 100, 100, 3'b000);
    pix("px_net_on", 1'b1, 319, 5, NET_RGB);
    pix("px_net_gap", 1'b1, 319, 20, 3'b000);
    bus.iActive = 1'b0;

    // Serve timing.
    repeat (59) frame();
    check("serve59_state", 32'(dut.state), 0);
    check("serve59_bx", 32'(dut.bx), 316);
    check("serve59_by", 32'(dut.by), 236);
    frame();
    check("serve60_state", 32'(dut.state), 1);
    check("serve60_bx", 32'(dut.bx), 316);
    frame();
    check("play1_bx", 32'(dut.bx), 318);
    check("play1_by", 32'(dut.by), 238);

    // Reset mid-PLAY with ball at (400,100) being drawn.
    force_ball(2'd1, 400, 100, 1'b0, 1'b0);
    pix("pre_rst_ball", 1'b1, 400, 100, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.iActive = 1'b0;
    check("mid_rst_rgb", 32'(bus.oRGB), 0);
    check("mid_rst_bx", 32'(dut.bx), 316);
    check("mid_rst_by", 32'(dut.by), 236);
    check("mid_rst_state", 32'(dut.state), 0);
    check("mid_rst_go", 32'(bus.oGameOver), 0);

    // Paddles: saturate at top, hold on both buttons.
    bus.iP1Up = 1'b1;
    bus.iP2Up = 1'b1;
    repeat (50) frame();
    check("p1_up50", 32'(dut.p1y), 8);
    check("p2_up50", 32'(dut.p2y), 8);
    bus.iP2Up = 1'b0;
    frame();
    check("p1_up_a", 32'(dut.p1y), 4);
    frame();
    check("p1_up_b", 32'(dut.p1y), 0);
    frame();
    check("p1_up_sat", 32'(dut.p1y), 0);
    check("p2_hold", 32'(dut.p2y), 8);
    force_p1(100);
    bus.iP1Dn = 1'b1;
    frame();
    check("p1_both", 32'(dut.p1y), 100);
    bus.iP1Up = 1'b0;
    bus.iP1Dn = 1'b0;
    do_reset();
    bus.iP1Dn = 1'b1;
    repeat (52) frame();
    check("p1_dn52", 32'(dut.p1y), 416);
    frame();
    check("p1_dn_sat", 32'(dut.p1y), 416);
    bus.iP1Dn = 1'b0;

    // Bounces.
    do_reset();
    force_ball(2'd1, 100, 100, 1'b1, 1'b0);
    frame();
    check("mv_bx", 32'(dut.bx), 98);
    check("mv_by", 32'(dut.by), 102);
    force_ball(2'd1, 200, 1, 1'b0, 1'b1);
    frame();
    check("top_by", 32'(dut.by), 0);
    check("top_dyn", 32'(dut.dy_neg), 0);
    check("top_bx", 32'(dut.bx), 202);
    force_ball(2'd1, 200, 471, 1'b0, 1'b0);
    frame();
    check("bot_by", 32'(dut.by), 472);
    check("bot_dyn", 32'(dut.dy_neg), 1);
    force_p1(0);
    force_ball(2'd1, 20, 1, 1'b1, 1'b1);
    frame();
    check("corner_by", 32'(dut.by), 0);
    check("corner_dyn", 32'(dut.dy_neg), 0);
    check("corner_dxn", 32'(dut.dx_neg), 0);
    check("corner_bx", 32'(dut.bx), 24);
    force_ball(2'd1, 610, 236, 1'b0, 1'b0);
    frame();
    check("p2hit_bx", 32'(dut.bx), 608);
    check("p2hit_dxn", 32'(dut.dx_neg), 1);
    check("p2hit_by", 32'(dut.by), 238);
    check("bounce_score1", 32'(bus.oScore1), 0);
    check("bounce_score2", 32'(bus.oScore2), 0);

    // Misses and game over.
    do_reset();
    force_p1(0);
    force_ball(2'd1, 632, 100, 1'b0, 1'b0);
    frame();
    check("rmiss_score1", 32'(bus.oScore1), 1);
    check("rmiss_bx", 32'(dut.bx), 316);
    check("rmiss_by", 32'(dut.by), 236);
    check("rmiss_dxn", 32'(dut.dx_neg), 0);
    check("rmiss_state", 32'(dut.state), 0);
    for (int k = 1; k <= 9; k++) begin
      force_ball(2'd1, 0, 300, 1'b1, 1'b0);
      frame();
      check("lmiss_score2", 32'(bus.oScore2), 32'(k));
      check("lmiss_bx", 32'(dut.bx), 316);
      check("lmiss_dxn", 32'(dut.dx_neg), 1);
      if (k < 9) begin
        check("lmiss_state", 32'(dut.state), 0);
        check("lmiss_go", 32'(bus.oGameOver), 0);
      end
    end
    check("win_go", 32'(bus.oGameOver), 1);
    check("win_state", 32'(dut.state), 2);
    check("win_score1", 32'(bus.oScore1), 1);
    bus.iP1Dn = 1'b1;
    bus.iP2Up = 1'b1;
    frame();
    frame();
    check("over_p1y", 32'(dut.p1y), 0);
    check("over_p2y", 32'(dut.p2y), 208);
    check("over_bx", 32'(dut.bx), 316);
    check("over_go", 32'(bus.oGameOver), 1);
    check("over_score2", 32'(bus.oScore2), 9);
    bus.iP1Dn = 1'b0;
    bus.iP2Up = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
